// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART slave on the PicoRV32 native bus.
// Define UART_IRQ_EN to add the irq output and the IRQ_EN register at 0x10.
module uart_mmio #(
    parameter int DEFAULT_DIV = 434,
    parameter int DIV_W       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        uart_txd,
    input  logic        uart_rxd
`ifdef UART_IRQ_EN
    ,
    output logic        irq
`endif
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           tx_st_q, tx_st_d, rx_st_q, rx_st_d;
    logic             ready_q, rx_s1_q, rx_s2_q, txd_q, txd_d;
    logic             rx_valid_q, rx_valid_d, overrun_q, overrun_d, frame_err_q, frame_err_d;
    logic [31:0]      rdata_q, rdata_d, div_wr, wmask, irq_rd;
    logic [DIV_W-1:0] div_q, div_d, tx_div_q, tx_div_d, tx_cnt_q, tx_cnt_d;
    logic [DIV_W-1:0] rx_div_q, rx_div_d, rx_cnt_q, rx_cnt_d;
    logic [2:0]       sel, tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [7:0]       tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_byte_q, rx_byte_d;
    logic             wr, tx_wr, acc, rd_rx, st_wr, tx_busy, tx_last, rx_last, rx_load, rx_bad;
    logic             unused_ok;

`ifdef UART_IRQ_EN
    logic [1:0] irq_en_q, irq_en_d;
    logic       irq_q;
    assign sel      = mem_addr[4:2];
    assign irq_rd   = {30'b0, irq_en_q};
    assign irq_en_d = (acc && mem_wstrb[0] && sel == 3'd4) ? mem_wdata[1:0] : irq_en_q;
    assign irq      = irq_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en_q <= 2'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= (irq_en_q[0] & rx_valid_q) | (irq_en_q[1] & ~tx_busy);
        end
    end
`else
    assign sel    = {1'b0, mem_addr[3:2]};
    assign irq_rd = '0;
`endif

    // A TXDATA write while the transmitter is busy is held off, not dropped.
    assign tx_busy = tx_st_q != IDLE;
    assign wr      = |mem_wstrb;
    assign tx_wr   = mem_wstrb[0] && sel == 3'd0;
    assign acc     = mem_valid && !ready_q && !(tx_wr && tx_busy);
    assign rd_rx   = acc && !wr && sel == 3'd1;
    assign st_wr   = acc && mem_wstrb[0] && sel == 3'd2;
    assign wmask   = {{8{mem_wstrb[3]}}, {8{mem_wstrb[2]}}, {8{mem_wstrb[1]}}, {8{mem_wstrb[0]}}};
    assign div_wr  = (mem_wdata & wmask) | (32'(div_q) & ~wmask);
    assign div_d   = (acc && wr && sel == 3'd3)
                   ? (div_wr[DIV_W-1:0] < DIV_W'(2) ? DIV_W'(2) : div_wr[DIV_W-1:0]) : div_q;
    assign rdata_d = (!acc || wr) ? '0
                   : sel == 3'd1 ? {24'b0, rx_byte_q}
                   : sel == 3'd2 ? {28'b0, frame_err_q, overrun_q, rx_valid_q, tx_busy}
                   : sel == 3'd3 ? 32'(div_q)
                   : sel == 3'd4 ? irq_rd : '0;
    assign tx_last     = tx_cnt_q == tx_div_q - DIV_W'(1);
    assign rx_last     = rx_cnt_q == rx_div_q - DIV_W'(1);
    assign rx_byte_d   = rx_load ? rx_sh_q : rx_byte_q;
    // A read racing a load returns the old byte and consumes it, so no overrun.
    assign rx_valid_d  = rx_load || (rx_valid_q && !rd_rx);
    assign overrun_d   = (rx_load && rx_valid_q && !rd_rx) || (overrun_q && !(st_wr && mem_wdata[2]));
    assign frame_err_d = rx_bad || (frame_err_q && !(st_wr && mem_wdata[3]));
    assign mem_ready   = ready_q;
    assign mem_rdata   = rdata_q;
    assign uart_txd    = txd_q;
    assign unused_ok   = ^{mem_addr, mem_wdata, div_wr};

    always_comb begin
        tx_st_d  = tx_st_q;
        tx_div_d = tx_div_q;
        tx_cnt_d = (tx_st_q == IDLE || tx_last) ? '0 : tx_cnt_q + DIV_W'(1);
        tx_bit_d = tx_bit_q;
        tx_sh_d  = tx_sh_q;
        txd_d    = txd_q;
        case (tx_st_q)
            IDLE: if (acc && tx_wr) begin
                tx_st_d  = START;
                tx_div_d = div_q;
                tx_sh_d  = mem_wdata[7:0];
                txd_d    = 1'b0;
            end
            START: if (tx_last) begin
                tx_st_d  = DATA;
                tx_bit_d = '0;
                txd_d    = tx_sh_q[0];
            end
            DATA: if (tx_last) begin
                tx_st_d  = tx_bit_q == 3'd7 ? STOP : DATA;
                tx_bit_d = tx_bit_q + 3'd1;
                tx_sh_d  = tx_sh_q >> 1;
                txd_d    = tx_bit_q == 3'd7 ? 1'b1 : tx_sh_q[1];
            end
            default: if (tx_last) tx_st_d = IDLE;
        endcase
    end

    always_comb begin
        rx_st_d  = rx_st_q;
        rx_div_d = rx_div_q;
        rx_cnt_d = rx_st_q == IDLE ? '0 : rx_cnt_q + DIV_W'(1);
        rx_bit_d = rx_bit_q;
        rx_sh_d  = rx_sh_q;
        rx_load  = 1'b0;
        rx_bad   = 1'b0;
        case (rx_st_q)
            IDLE: if (!rx_s2_q) begin
                rx_st_d  = START;
                rx_div_d = div_q;
            end
            START: if (rx_cnt_q == rx_div_q >> 1) begin
                rx_st_d  = rx_s2_q ? IDLE : DATA;
                rx_cnt_d = '0;
                rx_bit_d = '0;
            end
            DATA: if (rx_last) begin
                rx_st_d  = rx_bit_q == 3'd7 ? STOP : DATA;
                rx_cnt_d = '0;
                rx_bit_d = rx_bit_q + 3'd1;
                rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
            end
            default: if (rx_last) begin
                rx_st_d = IDLE;
                rx_load = rx_s2_q;
                rx_bad  = !rx_s2_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q     <= 1'b0;
            rdata_q     <= '0;
            div_q       <= DIV_W'(DEFAULT_DIV);
            tx_st_q     <= IDLE;
            tx_div_q    <= DIV_W'(DEFAULT_DIV);
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_sh_q     <= '0;
            txd_q       <= 1'b1;
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_st_q     <= IDLE;
            rx_div_q    <= DIV_W'(DEFAULT_DIV);
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_sh_q     <= '0;
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            ready_q     <= acc;
            rdata_q     <= rdata_d;
            div_q       <= div_d;
            tx_st_q     <= tx_st_d;
            tx_div_q    <= tx_div_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_sh_q     <= tx_sh_d;
            txd_q       <= txd_d;
            rx_s1_q     <= uart_rxd;
            rx_s2_q     <= rx_s1_q;
            rx_st_q     <= rx_st_d;
            rx_div_q    <= rx_div_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_sh_q     <= rx_sh_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end
endmodule

// File: tb/tb_uart_mmio.sv
// tb_uart_mmio: scoreboard bench for uart_mmio; bus reads and transmitted frames are checked against queued expectations.
module tb_uart_mmio;
    logic        clk = 1'b0, rst = 1'b1, mem_valid = 1'b0, mem_ready, uart_txd, uart_rxd;
    logic        loop = 1'b0, rxd_drv = 1'b1, mon_en = 1'b1, prev_rdy = 1'b0;
    logic [31:0] mem_addr = '0, mem_wdata = '0, mem_rdata, rd_v;
    logic [3:0]  mem_wstrb = '0;
    logic [9:0]  mon_f;
    int          checks = 0, failures = 0, tb_div = 434, lat, mon_d;
    logic [31:0] sb_q[$];
    logic [7:0]  tx_q[$];

    always #5 clk = ~clk;
    assign uart_rxd = loop ? uart_txd : rxd_drv;

    uart_mmio dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .uart_txd(uart_txd), .uart_rxd(uart_rxd)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic bus(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                       output logic [31:0] rdv, output int l);
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = a;
        mem_wdata = wd;
        mem_wstrb = st;
        l = 0;
        do begin
            @(negedge clk);
            l++;
        end while (!mem_ready && l < 2000);
        if (!mem_ready) check("bus_timeout", 32'(mem_ready), 1);
        rdv = mem_rdata;
        mem_valid = 1'b0;
        mem_wstrb = '0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] r;
        int l;
        bus(a, wd, 4'hF, r, l);
        check("wr_lat", l, 1);
        check("wr_rdata", r, 0);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] r;
        int l;
        sb_q.push_back(exp);
        bus(a, 0, 4'h0, r, l);
        check(tag, r, sb_q.pop_front());
        check({tag, "_lat"}, l, 1);
        @(negedge clk);
        check({tag, "_idle"}, mem_rdata, 0);
    endtask

    task automatic rx_send(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd_drv = f[i];
            repeat (tb_div) @(negedge clk);
        end
        rxd_drv = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mem_ready) check("ready_pulse", 32'(prev_rdy), 0);
        prev_rdy = mem_ready;
    end

    // Frame sampler: mid-bit samples of start, 8 data bits and stop.
    initial forever begin
        @(negedge clk);
        if (mon_en && uart_txd === 1'b0) begin
            mon_d = tb_div;
            for (int i = 0; i < 10; i++) begin
                repeat (i == 0 ? mon_d / 2 : mon_d) @(negedge clk);
                mon_f[i] = uart_txd;
            end
            check("tx_frame", 32'(mon_f),
                  tx_q.size() != 0 ? {22'b0, 1'b1, tx_q.pop_front(), 1'b0} : 32'hFFFF_FFFF);
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(mem_ready), 0);
        check("rst_rdata", mem_rdata, 0);
        check("rst_txd", 32'(uart_txd), 1);
        rst = 1'b0;
        rd(32'hC, 434, "div_rst");
        rd(32'h8, 0, "status_rst");
        wr(32'hC, 8);
        tb_div = 8;
        tx_q.push_back(8'hA5);
        wr(32'h0, 32'hA5);
        repeat (20) @(negedge clk);
        rd(32'h8, 1, "status_busy");
        repeat (80) @(negedge clk);
        rd(32'h8, 0, "status_idle");
        rd(32'h0, 0, "txdata_rd");
        loop = 1'b1;
        tx_q.push_back(8'h55);
        wr(32'h0, 32'h55);
        repeat (120) @(negedge clk);
        rd(32'h8, 2, "status_rx");
        rd(32'h4, 32'h55, "rxdata");
        rd(32'h8, 0, "status_rx_clr");
        tx_q.push_back(8'h11);
        wr(32'h0, 32'h11);
        tx_q.push_back(8'h22);
        bus(32'h0, 32'h22, 4'h1, rd_v, lat);
        check("tx_stall_lat", lat, 80);
        check("tx_stall_rdata", rd_v, 0);
        repeat (120) @(negedge clk);
        rd(32'h8, 6, "status_ovr");
        rd(32'h4, 32'h22, "rxdata_ovr");
        rd(32'h8, 4, "status_ovr_left");
        wr(32'h8, 4);
        rd(32'h8, 0, "status_w1c");
        loop = 1'b0;
        repeat (20) @(negedge clk);
        rx_send(8'h3C, 1'b0);
        repeat (40) @(negedge clk);
        rd(32'h8, 8, "status_ferr");
        rd(32'h4, 32'h22, "rx_discard");
        wr(32'h8, 8);
        rd(32'h8, 0, "status_ferr_clr");
        rx_send(8'h3C, 1'b1);
        repeat (40) @(negedge clk);
        rd(32'h8, 2, "status_rx2");
        rd(32'h4, 32'h3C, "rxdata2");
        rxd_drv = 1'b0;
        repeat (2) @(negedge clk);
        rxd_drv = 1'b1;
        repeat (40) @(negedge clk);
        rd(32'h8, 0, "status_glitch");
        wr(32'hC, 1);
        rd(32'hC, 2, "div_min");
        bus(32'hC, 32'h100, 4'b0010, rd_v, lat);
        rd(32'hC, 32'h102, "div_lane");
        wr(32'hC, 8);
        mon_en = 1'b0;
        wr(32'h0, 32'h00);
        repeat (20) @(negedge clk);
        check("txd_mid", 32'(uart_txd), 0);
        rst = 1'b1;
        @(negedge clk);
        check("txd_rst", 32'(uart_txd), 1);
        rst = 1'b0;
        rd(32'h8, 0, "status_after_rst");
        rd(32'hC, 434, "div_after_rst");
        repeat (10) @(negedge clk);
        check("tx_q_empty", tx_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_mmio.md
Name: uart_mmio

Overview:
- Memory-mapped 8N1 UART slave on the PicoRV32 native memory bus (valid/ready, wstrb byte lanes).
- The system decodes the 0x5xxx_xxxx region and gates mem_valid into this block; the block itself decodes only mem_addr[3:2].
- Provides a blocking transmit path, a single-byte receive holding register, a status register and a programmable baud divisor.

Parameters:
- DEFAULT_DIV, 434, reset value of the divisor register (clock cycles per bit; 50 MHz / 115200).
- DIV_W, 16, width of the divisor register and bit counters.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- mem_valid  in  1  access request, already qualified by the region select.
- mem_ready  out  1  access-complete pulse.
- mem_addr  in  32  byte address; only [3:2] used.
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  byte write strobes; 0 means read.
- mem_rdata  out  32  read data, valid while mem_ready=1.
- uart_txd  out  1  serial output, idle high.
- uart_rxd  in  1  serial input, asynchronous.

Behaviour:
- Reset: mem_ready=0, mem_rdata=0, uart_txd=1, divisor=DEFAULT_DIV, all flags 0, both FSMs IDLE.
- Register map (offset = mem_addr[3:2]*4):
  - 0x0 TXDATA (W): wstrb[0] with wdata[7:0] starts a frame. Reads return 0.
  - 0x4 RXDATA (R): returns {24'b0, rx_byte} and clears rx_valid in the same ready cycle. Writes are ignored.
  - 0x8 STATUS: bit0 tx_busy, bit1 rx_valid, bit2 overrun, bit3 frame_err, other bits 0. Writing 1 to bit2 or bit3 (wstrb[0]) clears that bit (W1C).
  - 0xC DIV: R/W [DIV_W-1:0], honours wstrb[0]/[1]. A written value below 2 is stored as 2.
- Handshake:
  - mem_ready is asserted for exactly one cycle, in the cycle after mem_valid is sampled high with mem_ready low. Fixed latency 1.
  - mem_ready is never asserted on two consecutive cycles.
  - mem_rdata is driven only during the ready cycle and is 0 otherwise.
- TXDATA write while tx_busy: mem_ready is withheld until the transmitter returns to IDLE, then the write is accepted (blocking). A CPU putc therefore never loses bytes.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - The divisor is latched at frame start.
  - Each bit lasts DIV clocks: start=0, data bits LSB first, stop=1.
  - tx_busy=1 from the cycle after acceptance through the end of the stop bit.
  - uart_txd changes in the cycle after acceptance.
- RX path:
  - 2-flop synchroniser on uart_rxd.
  - RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE waits for a synchronised 0.
  - START samples at DIV/2; a 1 there aborts to IDLE (glitch reject).
  - 8 data bits are sampled every DIV clocks, LSB first; the stop bit is sampled DIV clocks later.
  - Stop=1: the byte goes to rx_byte and rx_valid=1. If rx_valid was already 1, the old byte is overwritten and overrun=1.
  - Stop=0: the byte is discarded and frame_err=1.
  - RX returns to IDLE immediately after sampling stop.
- Simultaneous RXDATA read and new-byte load in the same cycle: the read returns the old byte, rx_valid stays 1 (new byte), overrun is not set.
- Divisor write during a frame affects only subsequent frames, on both TX and RX.
- Reset mid-frame: uart_txd returns to 1 in the next cycle; the partial RX byte is dropped.
- Counters are DIV_W wide and compared with ==; no wrap-around within a bit period.

Optional Feature:
- UART_IRQ_EN, defined:
  - Adds output irq (1 bit).
  - Adds register 0x10 IRQ_EN (bit0 rx_valid, bit1 tx idle), reset 0; decode then uses mem_addr[4:2].
  - irq = (IRQ_EN[0] & rx_valid) | (IRQ_EN[1] & ~tx_busy), registered, level-sensitive, reset 0.
- UART_IRQ_EN undefined: no irq port, no 0x10 register; 0x10 aliases to 0x0 through the [3:2] decode.

Test Plan:
- Reset then read DIV -> mem_rdata=434 in the ready cycle, one cycle after valid. Read STATUS -> 0. uart_txd=1.
- Write DIV=8, then TXDATA=0xA5 -> txd low 8 clocks, then bits 1,0,1,0,0,1,0,1 for 8 clocks each, then high 8 clocks. STATUS bit0=1 during the frame, 0 after.
- Loopback txd->rxd, DIV=8, write 0x55 -> after about 10 bit times STATUS=0x2 and RXDATA reads 0x55. A following STATUS read returns 0x0.
- Loopback, two bytes 0x11 then 0x22 with no RXDATA read -> second TXDATA write stalls mem_ready until the first frame ends. Final RXDATA=0x22, STATUS bit2=1. Writing STATUS=0x4 clears it.
- Drive rxd: start bit, 0x3C, then stop=0 -> rx_valid=0, frame_err=1. A 2-clock low glitch at DIV=8 -> no reception, no flags.
- Write DIV=1 -> reads back 2. Assert rst mid-TX frame -> txd=1 next cycle, STATUS=0, DIV=434.
